// File: rtl/yarp_pkg.sv
// Shared types and constants for the yarp core's performance-counter unit.
package yarp_pkg;

    typedef enum logic [1:0] {
        PERF_IDLE   = 2'd0,
        PERF_RUN    = 2'd1,
        PERF_FROZEN = 2'd2
    } perf_state_t;

    // Event input positions as wired in yarp_top
    localparam int EVT_ICACHE_BUSY = 0;
    localparam int EVT_DCACHE_BUSY = 1;
    localparam int EVT_INSTR_RET   = 2;
    localparam int EVT_BR_TAKEN    = 3;
    localparam int EVT_DMEM_REQ    = 4;

    localparam int PERF_NUM_EVT = 8;

endpackage

// File: rtl/yarp_perf_cnt_slice.sv
// One performance counter: event select, enable, live count, shadow and sticky overflow.
// Define YARP_PERF_SAT_EN to saturate at all-ones instead of wrapping.
module yarp_perf_cnt_slice #(
    parameter int CNT_W   = 32,
    parameter int NUM_EVT = 8,
    parameter int SEL_W   = (NUM_EVT > 1) ? $clog2(NUM_EVT) : 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               i_run,
    input  logic [NUM_EVT-1:0] i_evt_q,
    input  logic               i_cfg_we,
    input  logic [SEL_W-1:0]   i_cfg_evt_sel,
    input  logic               i_cfg_en,
    input  logic               i_clr,
    input  logic               i_snap,
    output logic [CNT_W-1:0]   o_cnt,
    output logic [CNT_W-1:0]   o_shadow,
    output logic               o_ovf
);

    logic [SEL_W-1:0] r_sel;
    logic             r_en;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_shadow;
    logic             r_ovf;
    logic             w_hit;
    logic             w_at_max;

    // Old select/enable are used in a config-write cycle since they are registers
    assign w_hit    = i_run && r_en && i_evt_q[r_sel];
    assign w_at_max = &r_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sel    <= '0;
            r_en     <= 1'b0;
            r_cnt    <= '0;
            r_shadow <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (i_cfg_we) begin
                r_sel <= i_cfg_evt_sel;
                r_en  <= i_cfg_en;
            end
            if (i_snap) begin
                r_shadow <= r_cnt;
            end
            if (i_clr) begin
                r_cnt <= '0;
                r_ovf <= 1'b0;
            end else if (w_hit) begin
                if (w_at_max) begin
                    r_ovf <= 1'b1;
                end
`ifdef YARP_PERF_SAT_EN
                if (!w_at_max) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
`else
                r_cnt <= r_cnt + CNT_W'(1);
`endif
            end
        end
    end

    assign o_cnt    = r_cnt;
    assign o_shadow = r_shadow;
    assign o_ovf    = r_ovf;

endmodule

// File: rtl/yarp_perf_counters.sv
// Performance-counter unit: run/freeze FSM, registered event stage, NUM_CNT counter slices,
// registered read mux and overflow interrupt. YARP_PERF_SAT_EN selects saturating counters.
module yarp_perf_counters
    import yarp_pkg::*;
#(
    parameter int  NUM_CNT = 4,
    parameter int  CNT_W   = 32,
    parameter int  NUM_EVT = PERF_NUM_EVT,
    localparam int IDX_W   = (NUM_CNT > 1) ? $clog2(NUM_CNT) : 1,
    localparam int SEL_W   = (NUM_EVT > 1) ? $clog2(NUM_EVT) : 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_EVT-1:0] evt_i,
    input  logic               start_i,
    input  logic               stop_i,
    input  logic               cfg_we_i,
    input  logic [IDX_W-1:0]   cfg_idx_i,
    input  logic [SEL_W-1:0]   cfg_evt_sel_i,
    input  logic               cfg_en_i,
    input  logic [NUM_CNT-1:0] clr_i,
    input  logic               snap_i,
    input  logic [IDX_W-1:0]   rd_idx_i,
    input  logic               rd_shadow_i,
    output logic [CNT_W-1:0]   rd_data_o,
    output logic [NUM_CNT-1:0] ovf_o,
    output logic               irq_o
);

    perf_state_t        r_state;
    perf_state_t        w_state_nxt;
    logic [NUM_EVT-1:0] r_evt_q;
    logic               w_run;
    logic [CNT_W-1:0]   w_cnt    [NUM_CNT];
    logic [CNT_W-1:0]   w_shadow [NUM_CNT];
    logic [CNT_W-1:0]   w_rd_data;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= PERF_IDLE;
            r_evt_q   <= '0;
            rd_data_o <= '0;
            irq_o     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_evt_q   <= evt_i;
            rd_data_o <= w_rd_data;
            irq_o     <= |ovf_o;
        end
    end

    // Simultaneous start and stop is treated as no request; IDLE is left only via start
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            PERF_IDLE:   if (start_i && !stop_i) w_state_nxt = PERF_RUN;
            PERF_RUN:    if (stop_i && !start_i) w_state_nxt = PERF_FROZEN;
            PERF_FROZEN: if (start_i && !stop_i) w_state_nxt = PERF_RUN;
            default:     w_state_nxt = PERF_IDLE;
        endcase
    end

    assign w_run = (r_state == PERF_RUN);

    always_comb begin
        w_rd_data = '0;
        if (int'(rd_idx_i) < NUM_CNT) begin
            w_rd_data = rd_shadow_i ? w_shadow[rd_idx_i] : w_cnt[rd_idx_i];
        end
    end

    for (genvar k = 0; k < NUM_CNT; k++) begin : g_slice
        yarp_perf_cnt_slice #(
            .CNT_W   (CNT_W),
            .NUM_EVT (NUM_EVT),
            .SEL_W   (SEL_W)
        ) u_slice (
            .clk           (clk),
            .reset_n       (reset_n),
            .i_run         (w_run),
            .i_evt_q       (r_evt_q),
            .i_cfg_we      (cfg_we_i && (cfg_idx_i == IDX_W'(k))),
            .i_cfg_evt_sel (cfg_evt_sel_i),
            .i_cfg_en      (cfg_en_i),
            .i_clr         (clr_i[k]),
            .i_snap        (snap_i),
            .o_cnt         (w_cnt[k]),
            .o_shadow      (w_shadow[k]),
            .o_ovf         (ovf_o[k])
        );
    end

endmodule

// File: tb/tb_yarp_perf_counters.sv
// Bench for yarp_perf_counters (8-bit counters so wrap is reachable): reference model plus
// directed scenarios and a randomized run.
module tb_yarp_perf_counters;

    localparam int NC   = 4;
    localparam int CW   = 8;
    localparam int NE   = 8;
    localparam int MAXV = 255;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [NE-1:0] evt_i = '0;
    logic          start_i = 1'b0;
    logic          stop_i = 1'b0;
    logic          cfg_we_i = 1'b0;
    logic [1:0]    cfg_idx_i = '0;
    logic [2:0]    cfg_evt_sel_i = '0;
    logic          cfg_en_i = 1'b0;
    logic [NC-1:0] clr_i = '0;
    logic          snap_i = 1'b0;
    logic [1:0]    rd_idx_i = '0;
    logic          rd_shadow_i = 1'b0;
    logic [CW-1:0] rd_data_o;
    logic [NC-1:0] ovf_o;
    logic          irq_o;

    yarp_perf_counters #(.NUM_CNT(NC), .CNT_W(CW), .NUM_EVT(NE)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .evt_i         (evt_i),
        .start_i       (start_i),
        .stop_i        (stop_i),
        .cfg_we_i      (cfg_we_i),
        .cfg_idx_i     (cfg_idx_i),
        .cfg_evt_sel_i (cfg_evt_sel_i),
        .cfg_en_i      (cfg_en_i),
        .clr_i         (clr_i),
        .snap_i        (snap_i),
        .rd_idx_i      (rd_idx_i),
        .rd_shadow_i   (rd_shadow_i),
        .rd_data_o     (rd_data_o),
        .ovf_o         (ovf_o),
        .irq_o         (irq_o)
    );

    always #5 clk = ~clk;

    // Reference model: state 0=idle, 1=run, 2=frozen
    int            m_cnt [NC];
    int            m_sh  [NC];
    int            m_sel [NC];
    bit            m_en  [NC];
    bit            m_ovf [NC];
    logic [NE-1:0] m_evtq = '0;
    int            m_state = 0;
    int            m_rd = 0;
    bit            m_irq = 1'b0;

    always @(posedge clk or negedge reset_n) begin : model
        bit any;
        bit inc;
        if (!reset_n) begin
            for (int k = 0; k < NC; k++) begin
                m_cnt[k] = 0; m_sh[k] = 0; m_sel[k] = 0; m_en[k] = 0; m_ovf[k] = 0;
            end
            m_evtq = '0; m_state = 0; m_rd = 0; m_irq = 0;
        end else begin
            any = 0;
            for (int k = 0; k < NC; k++) any = any | m_ovf[k];
            m_irq = any;
            m_rd  = rd_shadow_i ? m_sh[rd_idx_i] : m_cnt[rd_idx_i];
            for (int k = 0; k < NC; k++) begin
                if (snap_i) m_sh[k] = m_cnt[k];
                inc = (m_state == 1) && m_en[k] && m_evtq[m_sel[k]];
                if (clr_i[k]) begin
                    m_cnt[k] = 0;
                    m_ovf[k] = 0;
                end else if (inc) begin
                    if (m_cnt[k] == MAXV) begin
                        m_ovf[k] = 1;
`ifdef YARP_PERF_SAT_EN
                        m_cnt[k] = MAXV;
`else
                        m_cnt[k] = 0;
`endif
                    end else begin
                        m_cnt[k] = m_cnt[k] + 1;
                    end
                end
                if (cfg_we_i && (int'(cfg_idx_i) == k)) begin
                    m_sel[k] = int'(cfg_evt_sel_i);
                    m_en[k]  = cfg_en_i;
                end
            end
            m_evtq = evt_i;
            if (start_i && !stop_i && m_state != 1) m_state = 1;
            else if (stop_i && !start_i && m_state == 1) m_state = 2;
        end
    end

    // Compare process: per-cycle model check plus posted literal expectations
    int    total = 0;
    int    bad = 0;
    bit    chk_en = 1'b0;
    int    lit_id = 0;
    int    lit_seen = 0;
    int    lit_kind = 0;
    int    lit_exp = 0;
    string lit_name = "";

    task automatic chk(string nm, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin : compare
        int ovfv;
        ovfv = 0;
        for (int k = 0; k < NC; k++) ovfv = ovfv | (int'(m_ovf[k]) << k);
        if (chk_en) begin
            chk("rd_data", int'(rd_data_o), m_rd);
            chk("ovf", int'(ovf_o), ovfv);
            chk("irq", int'(irq_o), int'(m_irq));
        end
        if (lit_id != lit_seen) begin
            lit_seen = lit_id;
            case (lit_kind)
                0: begin
                    chk({lit_name, "_dut"}, int'(rd_data_o), lit_exp);
                    chk({lit_name, "_mdl"}, m_rd, lit_exp);
                end
                1: begin
                    chk({lit_name, "_dut"}, int'(ovf_o[0]), lit_exp);
                    chk({lit_name, "_mdl"}, int'(m_ovf[0]), lit_exp);
                end
                2: begin
                    chk({lit_name, "_dut"}, int'(irq_o), lit_exp);
                    chk({lit_name, "_mdl"}, int'(m_irq), lit_exp);
                end
                default: begin
                    chk({lit_name, "_dut"}, int'(ovf_o), lit_exp);
                    chk({lit_name, "_mdl"}, ovfv, lit_exp);
                end
            endcase
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        start_i  = 1'b0;
        stop_i   = 1'b0;
        cfg_we_i = 1'b0;
        clr_i    = '0;
        snap_i   = 1'b0;
    endtask

    task automatic lit(int kind, int exp, string nm);
        lit_kind = kind;
        lit_exp  = exp;
        lit_name = nm;
        lit_id++;
        @(negedge clk);
        #1;
    endtask

    task automatic cfg(int idx, int sel, bit en);
        cfg_we_i      = 1'b1;
        cfg_idx_i     = 2'(idx);
        cfg_evt_sel_i = 3'(sel);
        cfg_en_i      = en;
    endtask

    initial begin
        repeat (3) step();
        reset_n = 1'b1;
        chk_en  = 1'b1;
        lit(0, 0, "reset_rd");
        lit(3, 0, "reset_ovf");

        // Basic count of 10 on counter 0
        rd_idx_i = 2'd0;
        cfg(0, 0, 1'b1);
        step();
        start_i = 1'b1;
        evt_i   = 8'h01;
        repeat (10) step();
        evt_i = '0;
        repeat (3) step();
        lit(0, 10, "cnt0_ten");
        for (int k = 1; k < NC; k++) begin
            rd_idx_i = 2'(k);
            step();
            lit(0, 0, "idle_cnt");
        end
        rd_idx_i = 2'd0;

        // Freeze holds the count: 5 + 3 = 8
        clr_i = 4'b0001;
        step();
        evt_i = 8'h01;
        repeat (5) step();
        evt_i = '0;
        step();
        stop_i = 1'b1;
        step();
        evt_i = 8'h01;
        repeat (7) step();
        evt_i = '0;
        repeat (2) step();
        start_i = 1'b1;
        step();
        evt_i = 8'h01;
        repeat (3) step();
        evt_i = '0;
        repeat (3) step();
        lit(0, 8, "freeze");

        // Overflow at 8 bits
        clr_i = 4'b0001;
        step();
        evt_i = 8'h01;
        repeat (255) step();
        evt_i = '0;
        repeat (3) step();
        lit(0, 255, "preload");
        lit(1, 0, "pre_ovf");
        evt_i = 8'h01;
        step();
        evt_i = '0;
        repeat (3) step();
`ifdef YARP_PERF_SAT_EN
        lit(0, 255, "sat_hold");
`else
        lit(0, 0, "wrap");
`endif
        lit(1, 1, "ovf_set");
        lit(2, 1, "irq_set");

        // Snapshot with clear in the same cycle as an event
        clr_i = 4'b0001;
        step();
        evt_i = 8'h01;
        repeat (20) step();
        evt_i = '0;
        repeat (2) step();
        evt_i = 8'h01;
        step();
        evt_i  = '0;
        snap_i = 1'b1;
        clr_i  = 4'b0001;
        step();
        rd_shadow_i = 1'b1;
        step();
        lit(0, 20, "shadow");
        lit(1, 0, "ovf_clr");
        rd_shadow_i = 1'b0;
        step();
        lit(0, 0, "live_clr");

        // Reconfigure select on counter 1 in the cycle its old event is counted
        rd_idx_i = 2'd1;
        cfg(1, 2, 1'b1);
        clr_i = 4'b0010;
        step();
        evt_i = 8'h04;
        step();
        evt_i = 8'h08;
        cfg(1, 3, 1'b1);
        step();
        evt_i = '0;
        repeat (3) step();
        lit(0, 2, "reconfig");
        start_i = 1'b1;
        stop_i  = 1'b1;
        step();
        evt_i = 8'h08;
        step();
        evt_i = '0;
        repeat (3) step();
        lit(0, 3, "start_stop");

        // Asynchronous reset in the middle of counting
        evt_i = 8'h08;
        repeat (4) step();
        reset_n = 1'b0;
        lit(0, 0, "arst_rd");
        lit(3, 0, "arst_ovf");
        lit(2, 0, "arst_irq");
        step();
        reset_n = 1'b1;
        cfg(1, 3, 1'b1);
        repeat (6) step();
        lit(0, 0, "no_restart");
        evt_i = '0;

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            evt_i         = NE'($urandom);
            start_i       = ($urandom_range(0, 15) == 0);
            stop_i        = ($urandom_range(0, 19) == 0);
            cfg_we_i      = ($urandom_range(0, 7) == 0);
            cfg_idx_i     = 2'($urandom);
            cfg_evt_sel_i = 3'($urandom);
            cfg_en_i      = ($urandom_range(0, 3) != 0);
            clr_i         = ($urandom_range(0, 31) == 0) ? NC'($urandom) : '0;
            snap_i        = ($urandom_range(0, 7) == 0);
            rd_idx_i      = 2'($urandom);
            rd_shadow_i   = 1'($urandom);
            @(posedge clk);
            #1;
        end
        step();
        @(negedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
